count_seq_monitor: RTL and testbench

// - Downstream consumer of the wrapping 1..MAX cycle counter.
// - Accepts counter samples over valid/ready and buffers them in a small FIFO.
// - Forwards the samples unchanged and in order to the next stage.
// - Checks that successive accepted samples follow the MIN..MAX wrap sequence.
// - Reports sequence errors and counts wrap events, for checking by the bounded model checker.

---
 rtl/count_seq_pkg.sv | 24 ++
 rtl/count_seq_fifo.sv | 49 ++++
 rtl/count_seq_monitor.sv | 143 ++++++++++++++
 tb/tb_count_seq_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the counter-sequence monitor.
//   state_t    checker FSM states
//   DEF_MIN    default lowest legal count value
//   DEF_MAX    default highest legal count value
//   next_exp() value expected to follow 'last' in the MIN..MAX wrap sequence
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int unsigned DEF_MIN = 1;
  localparam int unsigned DEF_MAX = 10;

  // Successor of 'last' in the wrapping sequence
  function automatic logic [31:0] next_exp(input logic [31:0] last,
                                           input logic [31:0] min_v,
                                           input logic [31:0] max_v);
    return (last == max_v) ? min_v : last + 32'd1;
  endfunction

endpackage

// File: rtl/count_seq_fifo.sv
// Small synchronous FIFO buffering counter samples.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write strobe (caller guarantees not full) and data
//   pop_i           read strobe (caller guarantees not empty)
//   data_o          head entry
//   full_o/empty_o  occupancy flags, derived from registered pointers only
//   level_o         number of stored entries
module count_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  // Storage and pointers; the extra pointer bit distinguishes full from empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/count_seq_monitor.sv
// Buffers and forwards wrapping-counter samples and checks their sequence.
//   clock, reset_n         clock, asynchronous active-low reset
//   in_valid/in_count      upstream sample, in_ready = FIFO not full
//   out_valid/out_count    FIFO head toward the next stage, out_ready accepts it
//   clear_err              return checker to IDLE (wins over a same-cycle sample)
//   seq_error              one-cycle pulse on entry to ERROR
//   err_state              high while in ERROR
//   err_count              saturating count of ERROR entries
//   wrap_count             wrapping count of accepted MAX->MIN transitions
module count_seq_monitor
  import count_seq_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned MIN   = DEF_MIN,
  parameter int unsigned MAX   = DEF_MAX,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_count,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_count,
  input  logic          out_ready,
  input  logic          clear_err,
  output logic          seq_error,
  output logic          err_state,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] wrap_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW:0]   level;

  state_t        state_q, state_d, eval_state;
  logic [W-1:0]  last_q, last_d;
  logic          seq_error_q, seq_error_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic [CW-1:0] wrap_count_q, wrap_count_d;
  logic [W-1:0]  exp_c;
  logic          in_range_c;
  logic          enter_err;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;

  count_seq_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  (in_count),
    .pop_i   (pop),
    .data_o  (out_count),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign exp_c      = W'(next_exp(32'(last_q), 32'(MIN), 32'(MAX)));
  assign in_range_c = (in_count >= W'(MIN)) && (in_count <= W'(MAX));

  // Next-state logic; a clear makes a same-cycle sample see IDLE rules
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    seq_error_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    enter_err    = 1'b0;
    eval_state   = clear_err ? IDLE : state_q;

    if (clear_err) state_d = IDLE;

    if (push) begin
      case (eval_state)
        IDLE: begin
          if (in_range_c) begin
            state_d = TRACK;
            last_d  = in_count;
          end else begin
            enter_err = 1'b1;
          end
        end
        TRACK: begin
          if (in_count == exp_c) begin
            last_d = in_count;
            if (last_q == W'(MAX) && in_count == W'(MIN))
              wrap_count_d = wrap_count_q + CW'(1);
          end else begin
            enter_err = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (enter_err) begin
      state_d     = ERROR;
      seq_error_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + CW'(1);
    end
  end

  // Checker state and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= '0;
      seq_error_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      seq_error_q  <= seq_error_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign seq_error  = seq_error_q;
  assign err_state  = (state_q == ERROR);
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

  // Structural invariants
  a_level_bound : assert property (@(posedge clock) disable iff (!reset_n)
    level <= (AW+1)'(DEPTH));
  a_err_follows : assert property (@(posedge clock) disable iff (!reset_n)
    seq_error && !clear_err |=> err_state);
  a_track_range : assert property (@(posedge clock) disable iff (!reset_n)
    state_q == TRACK |-> (last_q >= W'(MIN) && last_q <= W'(MAX)));

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed and randomized checks of count_seq_monitor against a queue-based model.
module tb_count_seq_monitor;

  localparam int W     = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 4;
  localparam int LO    = 1;
  localparam int HI    = 10;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_count = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_count;
  logic          out_ready = 1'b0;
  logic          clear_err = 1'b0;
  logic          seq_error;
  logic          err_state;
  logic [CW-1:0] err_count;
  logic [CW-1:0] wrap_count;

  count_seq_monitor dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_count   (in_count),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .out_ready  (out_ready),
    .clear_err  (clear_err),
    .seq_error  (seq_error),
    .err_state  (err_state),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clock = ~clock;

  // Reference model: queue of buffered samples plus sequence-checker bookkeeping
  int unsigned q[$];
  int          m_mode;   // 0 idle, 1 tracking, 2 error
  int unsigned m_last;
  int unsigned m_err;
  int unsigned m_wrap;
  bit          m_pulse;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_mode  = 0;
    m_last  = 0;
    m_err   = 0;
    m_wrap  = 0;
    m_pulse = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) chk("out_count", out_count, q[0]);
    chk("seq_error", seq_error, m_pulse);
    chk("err_state", err_state, m_mode == 2);
    chk("err_count", err_count, m_err);
    chk("wrap_count", wrap_count, m_wrap);
  endtask

  // One clock cycle: drive, check registered outputs, advance model, step to next negedge
  task automatic cyc(input logic v, input int unsigned d, input logic r, input logic c,
                     output bit acc);
    bit pop;
    int mode_eval;
    in_valid  = v;
    in_count  = W'(d);
    out_ready = r;
    clear_err = c;
    check_outputs();
    acc = v && (q.size() < DEPTH);
    pop = (q.size() > 0) && r;
    m_pulse = 0;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    mode_eval = c ? 0 : m_mode;
    if (c) m_mode = 0;
    if (acc) begin
      if (mode_eval == 0) begin
        if (d >= LO && d <= HI) begin m_mode = 1; m_last = d; end
        else m_pulse = 1;
      end else if (mode_eval == 1) begin
        if (d == (m_last % HI) + 1) begin
          if (m_last == HI) m_wrap = (m_wrap + 1) % (1 << CW);
          m_last = d;
        end else m_pulse = 1;
      end
    end
    if (m_pulse) begin
      m_mode = 2;
      if (m_err < (1 << CW) - 1) m_err++;
    end
    @(negedge clock);
  endtask

  task automatic push(input int unsigned d);
    bit acc;
    cyc(1'b1, d, 1'b1, 1'b0, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_err = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    check_outputs();
    chk("rst_out_count", out_count, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int unsigned nxt;
    int budget;

    // 1: ordered stream with a wrap
    do_reset();
    for (int i = 1; i <= HI; i++) push(i);
    push(1);
    push(2);
    idle(3);
    chk("t1_wrap", wrap_count, 1);

    // 2: backpressure then drain
    do_reset();
    nxt = 1;
    for (int k = 0; k < 6; k++) begin
      cyc(nxt <= 5, nxt, 1'b0, 1'b0, acc);
      if (acc) nxt++;
    end
    chk("t2_full", in_ready, 0);
    chk("t2_head", out_count, 1);
    budget = 0;
    while ((nxt <= 5 || q.size() > 0) && budget < 20) begin
      cyc(nxt <= 5, nxt, 1'b1, 1'b0, acc);
      if (acc) nxt++;
      budget++;
    end
    if (budget >= 20) chk("t2_drain_timeout", budget, 0);
    idle(1);

    // 3: skipped value
    do_reset();
    push(3);
    push(4);
    push(6);
    push(7);
    idle(3);
    chk("t3_err_count", err_count, 1);

    // 4: out-of-range first sample, then 5: clear with simultaneous sample
    do_reset();
    push(11);
    idle(2);
    chk("t4_err_state", err_state, 1);
    cyc(1'b1, 5, 1'b1, 1'b1, acc);
    push(6);
    idle(2);
    chk("t5_err_state", err_state, 0);
    chk("t5_err_count", err_count, 1);

    // 6: reset with entries buffered
    do_reset();
    cyc(1'b1, 1, 1'b0, 1'b0, acc);
    cyc(1'b1, 3, 1'b0, 1'b0, acc);
    cyc(1'b1, 5, 1'b0, 1'b0, acc);
    check_outputs();
    reset_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_err_count", err_count, 0);
    chk("t6_wrap_count", wrap_count, 0);
    chk("t6_err_state", err_state, 0);
    do_reset();

    // Randomized traffic biased toward the legal sequence
    for (int k = 0; k < 500; k++) begin
      int unsigned d;
      d = ($urandom_range(0, 99) < 80) ? (m_last % HI) + 1 : $urandom_range(0, 12);
      cyc(($urandom % 4) != 0, d, ($urandom % 4) != 0, $urandom_range(0, 24) == 0, acc);
    end
    idle(DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
